// File: rtl/dmem_wbuf.sv
// Data-memory front end with a 2-entry in-order write buffer, optional
// store-to-load forwarding, and a registered single-port backend handshake.
module dmem_wbuf #(
    parameter int READ_FWD = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic        MemReadM,
    input  logic [31:0] AddrM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_empty
);

    typedef enum logic [1:0] {IDLE, WR, RD, RDONE} state_t;

    state_t      state_reg;
    logic [29:0] addr_reg [2];
    logic [31:0] data_reg [2];
    logic [1:0]  count_reg;
    logic [31:0] rdata_reg;

    logic        store;
    logic        load;
    logic        full;
    logic        push;
    logic        pop;
    logic        wr_slot;
    logic [1:0]  hit;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^AddrM[1:0];

    // A simultaneous read+write request is a store; the read is dropped.
    assign store = MemWriteM;
    assign load  = MemReadM && !MemWriteM;
    assign full  = (count_reg == 2'd2);
    assign push  = store && !full;
    assign pop   = (state_reg == WR) && mem_req && mem_ack;

    // After a pop the surviving entry shifts to slot 0, so the free slot is count-pop.
    assign wr_slot = count_reg[0] ^ pop;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_match
            assign hit[gi] = (READ_FWD != 0) && (count_reg > 2'(gi)) &&
                             (addr_reg[gi] == AddrM[31:2]);
        end
    endgenerate

    // Slot 1 is always younger than slot 0, so it wins when both match.
    assign fwd_hit  = load && (|hit);
    assign fwd_data = hit[1] ? data_reg[1] : data_reg[0];

    assign StallM    = reset && ((store && full) ||
                                 (load && !fwd_hit && (state_reg != RDONE)));
    assign ReadDataM = fwd_hit ? fwd_data : rdata_reg;
    assign wb_empty  = (count_reg == 2'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                addr_reg[i] <= '0;
                data_reg[i] <= '0;
            end
            count_reg <= '0;
        end else begin
            if (pop) begin
                addr_reg[0] <= addr_reg[1];
                data_reg[0] <= data_reg[1];
            end
            if (push) begin
                addr_reg[wr_slot] <= AddrM[31:2];
                data_reg[wr_slot] <= WriteDataM;
            end
            count_reg <= count_reg + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata_reg <= '0;
        end else begin
            // Latch forwarded data too, so ReadDataM holds the last returned value.
            if (fwd_hit) begin
                rdata_reg <= fwd_data;
            end
            case (state_reg)
                IDLE: begin
                    if (count_reg != 2'd0) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {addr_reg[0], 2'b00};
                        mem_wdata <= data_reg[0];
                        state_reg <= WR;
                    end else if (push) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {AddrM[31:2], 2'b00};
                        mem_wdata <= WriteDataM;
                        state_reg <= WR;
                    end else if (load && !fwd_hit) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= {AddrM[31:2], 2'b00};
                        state_reg <= RD;
                    end
                end
                WR: begin
                    if (mem_req && mem_ack) begin
                        if (count_reg == 2'd2) begin
                            mem_addr  <= {addr_reg[1], 2'b00};
                            mem_wdata <= data_reg[1];
                        end else if (push) begin
                            mem_addr  <= {AddrM[31:2], 2'b00};
                            mem_wdata <= WriteDataM;
                        end else begin
                            mem_req   <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end
                end
                RD: begin
                    if (mem_req && mem_ack) begin
                        rdata_reg <= mem_rdata;
                        mem_req   <= 1'b0;
                        state_reg <= RDONE;
                    end
                end
                RDONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
